// File: rtl/seq_det_pkg.sv
// Shared types and constants for the round-robin scheduled sequence detector.
package seq_det_pkg;

    localparam int N_REQ  = 4;
    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;

    localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DRAIN,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/seq_det_core.sv
// Programmable Moore pattern detector: 4-bit history, saturating fill count,
// registered match flag that rises the cycle after the completing bit.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    output logic             y
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [2:0]       fill;
    logic [2:0]       fill_nxt;

    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], din};
        fill_nxt = (fill == 3'd4) ? fill : fill + 3'd1;
    end

    // A full window is required before any hit, so cleared history never matches.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
        end else if (en) begin
            hist <= hist_nxt;
            fill <= fill_nxt;
            y    <= (fill_nxt == 3'd4) && (hist_nxt == pattern);
        end else begin
            y    <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin arbiter that lends one shared serial pattern detector to four
// requesters, scanning each winner's byte MSB first and reporting the hit count.
module seq_det_sched
    import seq_det_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] data_in,
    input  logic                    cfg_we,
    input  logic [PAT_W-1:0]        cfg_pattern,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              done_id,
    output logic [3:0]              match_cnt
);

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [1:0]        winner;
    logic [1:0]        pick;
    logic [1:0]        idx;
    logic [2:0]        bitcnt;
    logic [WORD_W-1:0] word;
    logic [PAT_W-1:0]  pattern;
    logic              core_y;

    // Scan downward so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = rr_ptr + k[1:0];
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant     <= '0;
            winner    <= '0;
            rr_ptr    <= '0;
            bitcnt    <= '0;
            match_cnt <= '0;
            pattern   <= DEFAULT_PATTERN;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        winner <= pick;
                        grant  <= 4'b0001 << pick;
                        state  <= ST_LOAD;
                    end else if (cfg_we) begin
                        pattern <= cfg_pattern;
                    end
                end
                ST_LOAD: begin
                    bitcnt    <= '0;
                    match_cnt <= '0;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bitcnt <= bitcnt + 3'd1;
                    if (core_y) begin
                        match_cnt <= match_cnt + 4'd1;
                    end
                    if (bitcnt == 3'd7) begin
                        state <= ST_DRAIN;
                    end
                end
                // The final window's flag lands here, one cycle after its last bit.
                ST_DRAIN: begin
                    if (core_y) begin
                        match_cnt <= match_cnt + 4'd1;
                    end
                    state <= ST_REPORT;
                end
                ST_REPORT: begin
                    rr_ptr <= winner + 2'd1;
                    grant  <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            word <= data_in[{winner, 3'b000} +: WORD_W];
        end else if (state == ST_SHIFT) begin
            word <= {word[WORD_W-2:0], 1'b0};
        end
    end

    seq_det_core u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == ST_LOAD),
        .en      (state == ST_SHIFT),
        .din     (word[WORD_W-1]),
        .pattern (pattern),
        .y       (core_y)
    );

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_REPORT);
    assign done_id = winner;

endmodule
